// File: rtl/data_mem_ctrl.sv
// Data-memory controller between the core's EX/MEM boundary and a 32-bit word RAM
// without byte enables. Sub-word stores are done as a stalled read-modify-write.
// The controller also decodes one memory-mapped 8-bit LED register.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_1000,
    parameter logic [31:0] LED_ADDR    = 32'h0000_2000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wr_data_i,
    input  logic        memwrite_i,
    input  logic        memread_i,
    input  logic [3:0]  sign_mask_i,
    output logic [31:0] read_data_o,
    output logic        stall_o,
    output logic [7:0]  led_o,
    output logic        misaligned_o
);

    localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] RAM_END = {1'b0, ADDR_BASE} + ({1'b0, DEPTH_WORDS} << 2);

    typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    state_t           state_q, state_d;
    size_t            req_size;
    logic             ram_hit, led_hit, misalign, accept, req_any;
    logic             do_store, do_load, rmw_start, word_store;
    logic [IDX_W-1:0] word_idx, rd_idx, wr_idx;
    logic [31:0]      rd_word, wr_word, merged;
    logic             ram_we;

    logic [IDX_W-1:0] rmw_idx_q;
    logic [1:0]       rmw_off_q;
    logic             rmw_half_q;
    logic [15:0]      rmw_data_q;
    logic [31:0]      rmw_buf_q;

    logic [31:0]      load_word_q;
    logic [1:0]       load_off_q;
    size_t            load_size_q;
    logic             load_unsigned_q;
    logic [7:0]       lane8;
    logic [15:0]      lane16;

    logic [7:0]       led_q;
    logic             mis_q;

    // Classify the sampled request: size, target region, alignment and what gets done.
    always_comb begin
        case (sign_mask_i[2:0])
            3'b001:  req_size = SZ_BYTE;
            3'b011:  req_size = SZ_HALF;
            default: req_size = SZ_WORD;
        endcase
        ram_hit    = ({1'b0, addr_i} >= {1'b0, ADDR_BASE}) && ({1'b0, addr_i} < RAM_END);
        led_hit    = (addr_i[31:2] == LED_ADDR[31:2]);
        word_idx   = IDX_W'((addr_i - ADDR_BASE) >> 2);
        misalign   = ((req_size == SZ_HALF) && addr_i[0]) ||
                     ((req_size == SZ_WORD) && (addr_i[1:0] != 2'b00));
        accept     = (state_q == IDLE);
        req_any    = memread_i || memwrite_i;
        do_store   = accept && memwrite_i && !misalign;
        do_load    = accept && memread_i && !memwrite_i && !misalign;
        word_store = do_store && ram_hit && (req_size == SZ_WORD);
        rmw_start  = do_store && ram_hit && (req_size != SZ_WORD);
    end

    // Next-state logic for the read-modify-write sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rmw_start) state_d = RMW_RD;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall_o      = (state_q != IDLE);
    assign led_o        = led_q;
    assign misaligned_o = mis_q;

    // Single RAM port: reads the pending RMW word in RMW_RD, else the requested word.
    // Writes are suppressed under reset so an interrupted RMW leaves the word intact.
    always_comb begin
        rd_idx  = (state_q == RMW_RD) ? rmw_idx_q : word_idx;
        rd_word = mem[rd_idx];
        ram_we  = 1'b0;
        wr_idx  = word_idx;
        wr_word = wr_data_i;
        if (state_q == RMW_WR) begin
            ram_we  = !rst_i;
            wr_idx  = rmw_idx_q;
            wr_word = merged;
        end else if (word_store) begin
            ram_we  = !rst_i;
        end
    end

    // Overlay the latched byte or halfword onto the old RAM word.
    always_comb begin
        merged = rmw_buf_q;
        if (rmw_half_q) begin
            merged[{rmw_off_q[1], 4'b0000} +: 16] = rmw_data_q;
        end else begin
            merged[{rmw_off_q, 3'b000} +: 8] = rmw_data_q[7:0];
        end
    end

    // Extract and extend the registered load word using the latched offset and size.
    always_comb begin
        lane8       = load_word_q[{load_off_q, 3'b000} +: 8];
        lane16      = load_word_q[{load_off_q[1], 4'b0000} +: 16];
        read_data_o = load_word_q;
        case (load_size_q)
            SZ_BYTE: read_data_o = {{24{!load_unsigned_q && lane8[7]}}, lane8};
            SZ_HALF: read_data_o = {{16{!load_unsigned_q && lane16[15]}}, lane16};
            default: read_data_o = load_word_q;
        endcase
    end

    // RAM array write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (ram_we) mem[wr_idx] <= wr_word;
    end

    // Control state, LED register, sticky error flag, load result and RMW latches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            led_q           <= '0;
            mis_q           <= 1'b0;
            load_word_q     <= '0;
            load_off_q      <= '0;
            load_size_q     <= SZ_WORD;
            load_unsigned_q <= 1'b0;
            rmw_idx_q       <= '0;
            rmw_off_q       <= '0;
            rmw_half_q      <= 1'b0;
            rmw_data_q      <= '0;
            rmw_buf_q       <= '0;
        end else begin
            state_q <= state_d;
            if (accept && req_any && misalign) mis_q <= 1'b1;
            if (do_store && led_hit) led_q <= wr_data_i[7:0];
            if (rmw_start) begin
                rmw_idx_q  <= word_idx;
                rmw_off_q  <= addr_i[1:0];
                rmw_half_q <= (req_size == SZ_HALF);
                rmw_data_q <= wr_data_i[15:0];
            end
            if (state_q == RMW_RD) rmw_buf_q <= rd_word;
            if (do_load) begin
                load_off_q      <= addr_i[1:0];
                load_unsigned_q <= sign_mask_i[3];
                if (ram_hit) begin
                    load_word_q <= rd_word;
                    load_size_q <= req_size;
                end else begin
                    // LED and unmapped loads bypass extraction entirely.
                    load_word_q <= led_hit ? {24'b0, led_q} : '0;
                    load_size_q <= SZ_WORD;
                end
            end
        end
    end

endmodule
